ctrl_pipe: RTL and testbench

- Parametrised successor to the fixed E/M/W control-signal pipeline: carries a decoded control word from decode through NSTAGE downstream stages with per-stage valid bits.
- Adds a multicycle execute mode for mul/div-class ops: the op is held in E for MD_LAT cycles, upstream is stalled, and bubbles are injected into the stage after E.
- Supports a branch flush of E and a full-pipeline flush for exceptions.
- Sits between the main/ALU decoders and the datapath.

---
 rtl/ctrl_pipe.sv | 176 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline from decode through NSTAGE downstream
// stages (0 = E, 1 = M, 2 = W, ...), with a per-stage valid bit.
// Multicycle (mul/div class) ops are held in E for MD_LAT cycles. While
// the op is held, decode is stalled and bubbles are injected into stage 1.
// Also provides a branch flush of E and an exception flush of all stages.
//
// Optional feature: define CTRL_PIPE_PERF_EN to enable the stall and
// bubble performance counters. When it is undefined, both are tied to 0.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   ctrlD/validD/mdopD   decode control word, valid bit, multicycle flag
//   flushE         branch flush: bubble into E (ignored while stalled)
//   flush_all      exception flush: bubble every stage, abort multicycle op
//   ctrl_q         stage k word at bits [k*CW +: CW]
//   valid_q        per-stage valid bits
//   stall_o        freeze fetch/decode this cycle
//   md_busy        multicycle FSM in BUSY
//   md_done        final E-occupancy cycle of a multicycle op
//   perf_stall     stall-cycle count (optional)
//   perf_bubble    injected-bubble count (optional)
//
// state  | meaning
// S_IDLE | no multicycle op holding E (includes the op's final E cycle)
// S_BUSY | multicycle op holding E, upstream stalled, counter running
module ctrl_pipe #(
  parameter int CW     = 10,
  parameter int NSTAGE = 3,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        ctrlD,
  input  logic                 validD,
  input  logic                 mdopD,
  input  logic                 flushE,
  input  logic                 flush_all,
  output logic [NSTAGE*CW-1:0] ctrl_q,
  output logic [NSTAGE-1:0]    valid_q,
  output logic                 stall_o,
  output logic                 md_busy,
  output logic                 md_done,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_bubble
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               MD_MULTI = (MD_LAT > 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NSTAGE*CW-1:0]  ctrl_d;
  logic [NSTAGE-1:0]     valid_d;
  logic                  mdop_e_q, mdop_e_d;

  assign md_busy = (state_q == S_BUSY);
  assign stall_o = md_busy;
  assign md_done = valid_q[0] & mdop_e_q & ~stall_o;

  // Stage registers. Defaults are bubbles so flush_all needs no branch of its own.
  always_comb begin
    ctrl_d   = '0;
    valid_d  = '0;
    mdop_e_d = 1'b0;
    if (!flush_all) begin
      for (int k = 2; k < NSTAGE; k++) begin
        ctrl_d[k*CW +: CW] = ctrl_q[(k-1)*CW +: CW];
        valid_d[k]         = valid_q[k-1];
      end
      if (stall_o) begin
        // E holds its op; stage 1 takes the bubble left by the defaults.
        ctrl_d[0 +: CW] = ctrl_q[0 +: CW];
        valid_d[0]      = valid_q[0];
        mdop_e_d        = mdop_e_q;
      end else begin
        ctrl_d[CW +: CW] = ctrl_q[0 +: CW];
        valid_d[1]       = valid_q[0];
        if (!flushE) begin
          ctrl_d[0 +: CW] = ctrlD;
          valid_d[0]      = validD;
          mdop_e_d        = validD & mdopD;
        end
      end
    end
  end

  // Multicycle FSM: the down-counter covers the stalled cycles only; the
  // op's last E cycle is spent back in IDLE, which lets a following op be
  // captured at the edge that ends it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (MD_MULTI && !flushE && validD && mdopD) begin
          state_d = S_BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush_all) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      valid_q  <= '0;
      mdop_e_q <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      mdop_e_q <= mdop_e_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  // A hold edge and an honoured flushE never coincide (flushE is ignored
  // while stalled), so each edge adds at most one bubble.
  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_bubble_d = perf_bubble_q;
    if (flush_all) begin
      perf_stall_d  = '0;
      perf_bubble_d = '0;
    end else begin
      if (stall_o) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
      if (stall_o || flushE) begin
        perf_bubble_d = perf_bubble_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_stall  = perf_stall_q;
  assign perf_bubble = perf_bubble_q;
`else
  assign perf_stall  = '0;
  assign perf_bubble = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe at CW=10, NSTAGE=3, MD_LAT=4.
module tb_ctrl_pipe;

  localparam int CW = 10;
  localparam int NS = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [CW-1:0]  ctrlD;
  logic           validD, mdopD, flushE, flush_all;
  logic [NS*CW-1:0] ctrl_q;
  logic [NS-1:0]  valid_q;
  logic           stall_o, md_busy, md_done;
  logic [31:0]    perf_stall, perf_bubble;

  int n_cmp  = 0;
  int n_fail = 0;

  ctrl_pipe #(.CW(CW), .NSTAGE(NS), .MD_LAT(4), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrlD      (ctrlD),
    .validD     (validD),
    .mdopD      (mdopD),
    .flushE     (flushE),
    .flush_all  (flush_all),
    .ctrl_q     (ctrl_q),
    .valid_q    (valid_q),
    .stall_o    (stall_o),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .perf_stall (perf_stall),
    .perf_bubble(perf_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]    c;
    logic             v, m, fe, fa;
    logic [NS-1:0]    ev;
    logic [NS*CW-1:0] ec;
    logic             es, ed;
    logic [31:0]      eps, epb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [CW-1:0] c, input logic v, input logic m,
                       input logic fe, input logic fa);
    ctrlD = c; validD = v; mdopD = m; flushE = fe; flush_all = fa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef CTRL_PIPE_PERF_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  logic s_pat [9];
  logic d_pat [9];

  initial begin
    // {W, M, E} ordering for ec and ev
    vecs[0]  = '{10'h001, 1, 0, 0, 0, 3'b001, {10'h000, 10'h000, 10'h001}, 0, 0, 0, 0};
    vecs[1]  = '{10'h002, 1, 0, 0, 0, 3'b011, {10'h000, 10'h001, 10'h002}, 0, 0, 0, 0};
    vecs[2]  = '{10'h003, 1, 0, 0, 0, 3'b111, {10'h001, 10'h002, 10'h003}, 0, 0, 0, 0};
    vecs[3]  = '{10'h000, 0, 0, 0, 0, 3'b110, {10'h002, 10'h003, 10'h000}, 0, 0, 0, 0};
    vecs[4]  = '{10'h000, 0, 0, 0, 0, 3'b100, {10'h003, 10'h000, 10'h000}, 0, 0, 0, 0};
    vecs[5]  = '{10'h155, 1, 1, 0, 0, 3'b001, {10'h000, 10'h000, 10'h155}, 1, 0, 0, 0};
    vecs[6]  = '{10'h0AA, 1, 0, 0, 0, 3'b001, {10'h000, 10'h000, 10'h155}, 1, 0, 1, 1};
    vecs[7]  = '{10'h0AA, 1, 0, 1, 0, 3'b001, {10'h000, 10'h000, 10'h155}, 1, 0, 2, 2};
    vecs[8]  = '{10'h0AA, 1, 0, 0, 0, 3'b001, {10'h000, 10'h000, 10'h155}, 0, 1, 3, 3};
    vecs[9]  = '{10'h0AA, 1, 0, 0, 0, 3'b011, {10'h000, 10'h155, 10'h0AA}, 0, 0, 3, 3};
    vecs[10] = '{10'h0BB, 1, 0, 1, 0, 3'b110, {10'h155, 10'h0AA, 10'h000}, 0, 0, 3, 4};
    vecs[11] = '{10'h000, 0, 0, 0, 0, 3'b100, {10'h0AA, 10'h000, 10'h000}, 0, 0, 3, 4};

    s_pat = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
    d_pat = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

    rst = 1'b1;
    drive('0, 0, 0, 0, 0);
    #12;
    chk("reset ctrl_q",  ctrl_q, 0);
    chk("reset valid_q", valid_q, 0);
    chk("reset stall_o", stall_o, 0);
    chk("reset md_done", md_done, 0);
    chk("reset perf_stall", perf_stall, 0);
    chk("reset perf_bubble", perf_bubble, 0);
    rst = 1'b0;

    // Streaming, multicycle hold, ignored and honoured flushE
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].c, vecs[i].v, vecs[i].m, vecs[i].fe, vecs[i].fa);
      tick();
      chk($sformatf("v%0d valid_q", i), valid_q, vecs[i].ev);
      chk($sformatf("v%0d ctrl_q", i), ctrl_q, vecs[i].ec);
      chk($sformatf("v%0d stall_o", i), stall_o, vecs[i].es);
      chk($sformatf("v%0d md_busy", i), md_busy, vecs[i].es);
      chk($sformatf("v%0d md_done", i), md_done, vecs[i].ed);
      chk($sformatf("v%0d perf_stall", i), perf_stall, perf_exp(vecs[i].eps));
      chk($sformatf("v%0d perf_bubble", i), perf_bubble, perf_exp(vecs[i].epb));
    end

    // Asynchronous reset mid-cycle with every stage valid
    for (int i = 0; i < 3; i++) begin
      drive(CW'(10'h010 + i), 1, 0, 0, 0);
      tick();
    end
    chk("pre-reset valid_q", valid_q, 3'b111);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset ctrl_q", ctrl_q, 0);
    chk("async reset valid_q", valid_q, 0);
    rst = 1'b0;
    drive('0, 0, 0, 0, 0);

    // flush_all two edges into a multicycle op
    drive(10'h155, 1, 1, 0, 0);
    tick();
    chk("fa t0 stall_o", stall_o, 1);
    drive(10'h0AA, 1, 0, 0, 0);
    tick();
    chk("fa t0+1 stall_o", stall_o, 1);
    drive(10'h0AA, 1, 0, 0, 1);
    tick();
    chk("fa valid_q", valid_q, 0);
    chk("fa ctrl_q", ctrl_q, 0);
    chk("fa md_busy", md_busy, 0);
    chk("fa stall_o", stall_o, 0);
    chk("fa perf_stall", perf_stall, 0);
    chk("fa perf_bubble", perf_bubble, 0);
    drive(10'h0CC, 1, 0, 0, 0);
    tick();
    chk("post-fa valid_q", valid_q, 3'b001);
    chk("post-fa ctrl_q", ctrl_q, {10'h000, 10'h000, 10'h0CC});
    chk("post-fa stall_o", stall_o, 0);
    drive('0, 0, 0, 0, 0);
    repeat (3) tick();

    // Back-to-back multicycle ops
    drive(10'h111, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("b2b c%0d stall_o", i), stall_o, s_pat[i]);
      chk($sformatf("b2b c%0d md_done", i), md_done, d_pat[i]);
      if (i == 0) drive(10'h222, 1, 1, 0, 0);
      if (i == 4) begin
        chk("b2b M first op", ctrl_q[CW +: CW], 10'h111);
        chk("b2b E second op", ctrl_q[0 +: CW], 10'h222);
        drive('0, 0, 0, 0, 0);
      end
      if (i == 8) begin
        chk("b2b M second op", ctrl_q[CW +: CW], 10'h222);
        chk("b2b valid_q", valid_q, 3'b010);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
